// File: rtl/wb_spi_slave_if.sv
// Wishbone classic bus bundle between a host master and the wb_spi_slave register block.
interface wb_spi_slave_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_we_i;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
        input  wb_dat_o, wb_ack_o
    );
    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_spi_slave.sv
// SPI mode-0 slave (8-bit, MSB first) behind a Wishbone classic register map.
// Define SPI_SLAVE_RXFIFO_EN for a 4-entry RX FIFO; otherwise RX storage is a single byte.
module wb_spi_slave #(
    parameter int clk_freq = 50000000
) (
    input  logic          clk,
    input  logic          rst,
    wb_spi_slave_if.slave wb,
    input  logic          spi_sck,
    input  logic          spi_cs_n,
    input  logic          spi_mosi,
    output logic          spi_miso,
    output logic          spi_miso_oe,
    output logic          intr
);
`ifdef SPI_SLAVE_RXFIFO_EN
    localparam int RX_DEPTH = 4;
`else
    localparam int RX_DEPTH = 1;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t      state_q, state_d;
    logic [1:0]  sck_sync_q, cs_sync_q, mosi_sync_q;
    logic        sck_prev_q, cs_prev_q, live_q, armed_q, armed_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        reload_q, reload_d;
    logic [7:0]  rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d, tx_hold_q, tx_hold_d;
    logic        tx_empty_q, tx_empty_d, overrun_q, overrun_d, underrun_q, underrun_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic        ack_q, ack_d, rd_pop_q, rd_pop_d;
    logic [31:0] dat_q, dat_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]  rx_cnt_q, rx_cnt_d;
    logic        miso_q, miso_d, miso_oe_q, miso_oe_d;
    logic [7:0]  rx_mem [4];

    logic sck_rise, sck_fall, cs_fall, cs_rise, req, wr, tx_wr, st_wr, ctrl_wr, pop;
    logic rx_push, push_ok, load, rx_full, rx_avail, cs_active;
    logic [1:0] reg_sel;
    logic [7:0] rx_byte;
    logic [4:0] status;
    logic unused_bits;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(RX_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    assign sck_rise  = sck_sync_q[1] & ~sck_prev_q;
    assign sck_fall  = ~sck_sync_q[1] & sck_prev_q;
    // A falling CS only counts once a genuine high level has been seen since reset.
    assign cs_fall   = ~cs_sync_q[1] & cs_prev_q & armed_q;
    assign cs_rise   = cs_sync_q[1] & ~cs_prev_q;
    assign rx_byte   = {rx_shift_q[6:0], mosi_sync_q[1]};
    assign req       = wb.wb_stb_i & wb.wb_cyc_i;
    assign reg_sel   = wb.wb_adr_i[3:2];
    assign wr        = ack_q & req & wb.wb_we_i & wb.wb_sel_i[0];
    assign tx_wr     = wr & (reg_sel == 2'd1);
    assign st_wr     = wr & (reg_sel == 2'd2);
    assign ctrl_wr   = wr & (reg_sel == 2'd3);
    assign pop       = ack_q & req & rd_pop_q;
    assign rx_full   = (rx_cnt_q == 3'(RX_DEPTH));
    assign rx_avail  = (rx_cnt_q != 3'd0);
    assign cs_active = (state_q != IDLE);
    assign status    = {underrun_q, cs_active, overrun_q, tx_empty_q, rx_avail};
    assign unused_bits = ^{wb.wb_adr_i[31:4], wb.wb_adr_i[1:0], wb.wb_dat_i[31:8], wb.wb_sel_i[3:1]};

    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q | (live_q & cs_sync_q[0]);
        bit_cnt_d  = bit_cnt_q;
        reload_d   = reload_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        tx_hold_d  = tx_hold_q;
        tx_empty_d = tx_empty_q;
        overrun_d  = overrun_q;
        underrun_d = underrun_q;
        ctrl_d     = ctrl_q;
        rx_push    = 1'b0;
        load       = 1'b0;

        if (tx_wr) begin
            tx_hold_d  = wb.wb_dat_i[7:0];
            tx_empty_d = 1'b0;
        end
        if (st_wr) begin
            if (wb.wb_dat_i[2]) overrun_d = 1'b0;
            if (wb.wb_dat_i[4]) underrun_d = 1'b0;
        end
        if (ctrl_wr) ctrl_d = wb.wb_dat_i[1:0];

        case (state_q)
            IDLE: if (cs_fall) state_d = LOAD;
            LOAD: begin
                load    = 1'b1;
                state_d = cs_rise ? IDLE : SHIFT;
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end else if (sck_rise) begin
                    rx_shift_d = rx_byte;
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_push  = 1'b1;
                        reload_d = 1'b1;
                    end
                end else if (sck_fall) begin
                    if (reload_q) begin
                        load     = 1'b1;
                        reload_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (cs_rise) begin
            bit_cnt_d = 3'd0;
            reload_d  = 1'b0;
        end

        // A TXDATA write landing on a load goes straight to the shifter.
        if (load) begin
            if (tx_wr) begin
                tx_shift_d = wb.wb_dat_i[7:0];
                tx_empty_d = 1'b1;
            end else if (tx_empty_q) begin
                tx_shift_d = 8'hFF;
                underrun_d = 1'b1;
            end else begin
                tx_shift_d = tx_hold_q;
                tx_empty_d = 1'b1;
            end
        end

        push_ok = rx_push & (~rx_full | pop);
        if (rx_push & ~push_ok) overrun_d = 1'b1;
        wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        rx_cnt_d = rx_cnt_q + {2'b00, push_ok} - {2'b00, pop};

        miso_d    = (state_d != IDLE) ? tx_shift_d[7] : 1'b1;
        miso_oe_d = (state_d != IDLE);

        // Read data is latched on the request cycle; the RX pop happens on the ack cycle.
        ack_d    = req & ~ack_q;
        rd_pop_d = ack_d & ~wb.wb_we_i & (reg_sel == 2'd0) & rx_avail;
        dat_d    = 32'd0;
        if (ack_d & ~wb.wb_we_i) begin
            case (reg_sel)
                2'd0:    dat_d = rx_avail ? {24'd0, rx_mem[rd_ptr_q]} : 32'd0;
                2'd2:    dat_d = {27'd0, status};
                2'd3:    dat_d = {30'd0, ctrl_q};
                default: dat_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sck_sync_q  <= 2'b00;
            cs_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b00;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
            live_q      <= 1'b0;
            armed_q     <= 1'b0;
            bit_cnt_q   <= 3'd0;
            reload_q    <= 1'b0;
            rx_shift_q  <= 8'd0;
            tx_shift_q  <= 8'd0;
            tx_hold_q   <= 8'd0;
            tx_empty_q  <= 1'b1;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
            ctrl_q      <= 2'd0;
            ack_q       <= 1'b0;
            rd_pop_q    <= 1'b0;
            dat_q       <= 32'd0;
            wr_ptr_q    <= 2'd0;
            rd_ptr_q    <= 2'd0;
            rx_cnt_q    <= 3'd0;
            miso_q      <= 1'b1;
            miso_oe_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sck_sync_q  <= {sck_sync_q[0], spi_sck};
            cs_sync_q   <= {cs_sync_q[0], spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
            sck_prev_q  <= sck_sync_q[1];
            cs_prev_q   <= cs_sync_q[1];
            live_q      <= 1'b1;
            armed_q     <= armed_d;
            bit_cnt_q   <= bit_cnt_d;
            reload_q    <= reload_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            tx_hold_q   <= tx_hold_d;
            tx_empty_q  <= tx_empty_d;
            overrun_q   <= overrun_d;
            underrun_q  <= underrun_d;
            ctrl_q      <= ctrl_d;
            ack_q       <= ack_d;
            rd_pop_q    <= rd_pop_d;
            dat_q       <= dat_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rx_cnt_q    <= rx_cnt_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) rx_mem[wr_ptr_q] <= rx_byte;
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;
    assign spi_miso    = miso_q;
    assign spi_miso_oe = miso_oe_q;
    assign intr        = (ctrl_q[0] & rx_avail) | (ctrl_q[1] & tx_empty_q) | overrun_q;
endmodule

// File: tb/tb_wb_spi_slave.sv
// Directed scoreboard bench for wb_spi_slave; expectations follow SPI_SLAVE_RXFIFO_EN when defined.
module tb_wb_spi_slave;
    localparam int HALF = 80;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spi_sck = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
    logic spi_miso, spi_miso_oe, intr;
    logic [7:0] dummy_rx;
    logic [7:0] miso_byte;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_rd_q[$];
    string       rd_name_q[$];
    logic [7:0]  exp_miso_q[$];
    event        miso_ev;

    wb_spi_slave_if wbif();

    wb_spi_slave #(.clk_freq(100000000)) dut (
        .clk         (clk),
        .rst         (rst),
        .wb          (wbif),
        .spi_sck     (spi_sck),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .intr        (intr)
    );

    always #5 clk = ~clk;

    // Monitor: every read ack is checked against the oldest expected read value.
    always @(posedge clk) begin
        #1;
        if (wbif.wb_ack_o && !wbif.wb_we_i) begin
            checks++;
            if (exp_rd_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected got=0x%08h exp=none", wbif.wb_dat_o);
            end else begin
                logic [31:0] e;
                string nm;
                e  = exp_rd_q.pop_front();
                nm = rd_name_q.pop_front();
                if (wbif.wb_dat_o !== e) begin
                    errors++;
                    $display("FAIL %s got=0x%08h exp=0x%08h", nm, wbif.wb_dat_o, e);
                end else begin
                    $display("wb read %s data=0x%08h ok", nm, wbif.wb_dat_o);
                end
            end
        end
    end

    // Monitor: every completed SPI byte is checked against the expected MISO byte.
    always begin
        @(miso_ev);
        checks++;
        if (exp_miso_q.size() == 0) begin
            errors++;
            $display("FAIL miso_unexpected got=0x%02h exp=none", miso_byte);
        end else begin
            logic [7:0] e;
            e = exp_miso_q.pop_front();
            if (miso_byte !== e) begin
                errors++;
                $display("FAIL miso_byte got=0x%02h exp=0x%02h", miso_byte, e);
            end else begin
                $display("spi frame miso=0x%02h ok", miso_byte);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end else begin
            $display("check %s value=0x%0h ok", name, got);
        end
    endtask

    task automatic wb_cycle(input logic [1:0] idx, input logic we, input logic [31:0] d);
        int n;
        @(negedge clk);
        wbif.wb_adr_i = {28'd0, idx, 2'b00};
        wbif.wb_dat_i = d;
        wbif.wb_sel_i = 4'hF;
        wbif.wb_we_i  = we;
        wbif.wb_stb_i = 1'b1;
        wbif.wb_cyc_i = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!wbif.wb_ack_o && n < 20);
        if (!wbif.wb_ack_o) begin
            checks++;
            errors++;
            $display("FAIL wb_ack_timeout got=0 exp=1");
        end
        @(posedge clk);
        #1;
        chk("ack_single_cycle", {31'd0, wbif.wb_ack_o}, 32'd0);
        wbif.wb_stb_i = 1'b0;
        wbif.wb_cyc_i = 1'b0;
        wbif.wb_we_i  = 1'b0;
    endtask

    task automatic wb_write(input logic [1:0] idx, input logic [31:0] d);
        wb_cycle(idx, 1'b1, d);
    endtask

    task automatic wb_read(input logic [1:0] idx, input logic [31:0] e, input string nm);
        exp_rd_q.push_back(e);
        rd_name_q.push_back(nm);
        wb_cycle(idx, 1'b0, 32'd0);
    endtask

    task automatic cs_low();
        @(negedge clk);
        spi_cs_n = 1'b0;
        #HALF;
    endtask

    task automatic cs_high();
        #HALF;
        spi_cs_n = 1'b1;
        #(2 * HALF);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'd0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx[7-i];
            #HALF;
            spi_sck = 1'b1;
            rx = {rx[6:0], spi_miso};
            #HALF;
            spi_sck = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, input logic [7:0] exp_miso);
        logic [7:0] rx;
        exp_miso_q.push_back(exp_miso);
        spi_bits(tx, 8, rx);
        miso_byte = rx;
        ->miso_ev;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"},  {31'd0, wbif.wb_ack_o}, 32'd0);
        chk({tag, "_dat"},  wbif.wb_dat_o, 32'd0);
        chk({tag, "_intr"}, {31'd0, intr}, 32'd0);
        chk({tag, "_miso"}, {31'd0, spi_miso}, 32'd1);
        chk({tag, "_oe"},   {31'd0, spi_miso_oe}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wbif.wb_adr_i = 32'd0;
        wbif.wb_dat_i = 32'd0;
        wbif.wb_sel_i = 4'd0;
        wbif.wb_we_i  = 1'b0;
        wbif.wb_stb_i = 1'b0;
        wbif.wb_cyc_i = 1'b0;

        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset_outputs("por");
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        wb_read(2'd2, 32'h02, "status_reset");
        wb_read(2'd3, 32'h00, "ctrl_reset");
        wb_read(2'd0, 32'h00, "rx_empty_reset");

        // TX 0xA5 out, 0x3C in; the end-of-byte reload underruns.
        wb_write(2'd1, 32'hA5);
        wb_read(2'd2, 32'h00, "status_tx_loaded");
        cs_low();
        chk("oe_cs_active", {31'd0, spi_miso_oe}, 32'd1);
        chk("miso_first_bit", {31'd0, spi_miso}, 32'd1);
        spi_byte(8'h3C, 8'hA5);
        cs_high();
        wb_read(2'd2, 32'h13, "status_t1");
        wb_read(2'd0, 32'h3C, "rx_t1");
        wb_read(2'd2, 32'h12, "status_t1_after_pop");
        wb_write(2'd2, 32'h10);
        wb_read(2'd2, 32'h02, "status_t1_cleared");

        // No TX data: MISO idles 0xFF and underrun is flagged.
        cs_low();
        spi_byte(8'h96, 8'hFF);
        cs_high();
        wb_read(2'd2, 32'h13, "status_underrun");
        wb_read(2'd0, 32'h96, "rx_t2");
        wb_read(2'd0, 32'h00, "rx_t2_empty");
        wb_write(2'd2, 32'h10);
        wb_read(2'd2, 32'h02, "status_underrun_cleared");

        // Five bytes with no reads: RX storage overruns.
        cs_low();
        for (int b = 1; b <= 5; b++) spi_byte(8'(b), 8'hFF);
        cs_high();
        chk("intr_overrun", {31'd0, intr}, 32'd1);
        wb_read(2'd2, 32'h17, "status_overrun");
`ifdef SPI_SLAVE_RXFIFO_EN
        for (int b = 1; b <= 4; b++) wb_read(2'd0, 32'(b), "rx_t3_fifo");
`else
        wb_read(2'd0, 32'h01, "rx_t3_single");
`endif
        wb_read(2'd0, 32'h00, "rx_t3_empty");
        wb_read(2'd2, 32'h16, "status_t3_drained");
        wb_write(2'd2, 32'h14);
        wb_read(2'd2, 32'h02, "status_t3_cleared");
        chk("intr_overrun_cleared", {31'd0, intr}, 32'd0);

        // Aborted 5-bit frame, then a full 0x81 frame.
        cs_low();
        spi_bits(8'hAA, 5, dummy_rx);
        cs_high();
        wb_read(2'd2, 32'h12, "status_partial");
        wb_write(2'd2, 32'h10);
        wb_write(2'd1, 32'h5A);
        cs_low();
        spi_byte(8'h81, 8'h5A);
        cs_high();
        wb_read(2'd0, 32'h81, "rx_t4");
        wb_read(2'd0, 32'h00, "rx_t4_only_one");
        wb_read(2'd2, 32'h12, "status_t4");
        wb_write(2'd2, 32'h10);

        // RX interrupt follows rx_avail; TX interrupt follows tx_empty.
        wb_write(2'd3, 32'h1);
        wb_read(2'd3, 32'h1, "ctrl_readback");
        chk("intr_idle", {31'd0, intr}, 32'd0);
        cs_low();
        spi_byte(8'h55, 8'hFF);
        cs_high();
        chk("intr_rx", {31'd0, intr}, 32'd1);
        wb_read(2'd0, 32'h55, "rx_t5");
        repeat (2) @(negedge clk);
        chk("intr_rx_cleared", {31'd0, intr}, 32'd0);
        wb_write(2'd3, 32'h2);
        chk("intr_tx_empty", {31'd0, intr}, 32'd1);
        wb_write(2'd2, 32'h10);

        // Reset mid-frame after 3 bits, remaining bits ignored, then a clean 0xC3 frame.
        cs_low();
        spi_bits(8'hFF, 3, dummy_rx);
        chk("oe_before_reset", {31'd0, spi_miso_oe}, 32'd1);
        chk("intr_before_reset", {31'd0, intr}, 32'd1);
        #3;
        rst = 1'b0;
        #1;
        chk_reset_outputs("midframe");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        spi_bits(8'hFF, 5, dummy_rx);
        cs_high();
        wb_read(2'd2, 32'h02, "status_after_reset");
        wb_read(2'd3, 32'h00, "ctrl_after_reset");
        cs_low();
        spi_byte(8'hC3, 8'hFF);
        cs_high();
        wb_read(2'd0, 32'hC3, "rx_t6");
        wb_read(2'd0, 32'h00, "rx_t6_only_one");
        wb_read(2'd2, 32'h12, "status_t6");

        repeat (20) @(negedge clk);
        checks++;
        if (exp_rd_q.size() != 0 || exp_miso_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d/%0d exp=0/0", exp_rd_q.size(), exp_miso_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_spi_slave.md
WB_SPI_SLAVE -- requirements
Module: wb_spi_slave

Interface
REQ-001 SHALL have parameter clk_freq, default 50000000, system clock frequency in Hz, informational only.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports wb_adr_i in 32, wb_dat_i in 32, wb_dat_o out 32, wb_sel_i in 4, wb_stb_i in 1, wb_cyc_i in 1, wb_we_i in 1, wb_ack_o out 1: Wishbone classic slave.
REQ-005 SHALL have ports spi_sck in 1, spi_cs_n in 1, spi_mosi in 1 (driven by an external SPI master), spi_miso out 1, spi_miso_oe out 1.
REQ-006 SHALL have port intr  output  1  level interrupt, active-high.

Function
REQ-007 SHALL register-map on wb_adr_i[3:2]: 0 RXDATA (read pops one byte), 1 TXDATA (write bits [7:0]), 2 STATUS, 3 CTRL.
REQ-008 SHALL define STATUS bits: 0 rx_avail, 1 tx_empty, 2 overrun (write 1 clears), 3 cs_active, 4 underrun (write 1 clears); other bits read 0.
REQ-009 SHALL define CTRL bits: 0 rx_irq_en, 1 tx_irq_en; read back as written.
REQ-010 SHALL assert wb_ack_o for exactly one cycle, one cycle after stb&cyc, never on consecutive cycles; register side effects occur on the ack cycle only.
REQ-011 SHALL pass spi_sck, spi_cs_n, spi_mosi through 2-flop synchronisers and detect SCK edges on synchronised values; SCK up to clk_freq/8.
REQ-012 SHALL operate SPI mode 0, MSB first, 8-bit frames: sample MOSI on SCK rising, update MISO on SCK falling.
REQ-013 SHALL use states IDLE (CS high), LOAD (one cycle after CS fall), SHIFT (CS low); IDLE->LOAD on synced CS falling, LOAD->SHIFT unconditionally, any->IDLE on synced CS rising.
REQ-014 SHALL in LOAD copy TX holding register into TX shifter and set tx_empty; if tx_empty was already set, load 0xFF and set underrun.
REQ-015 SHALL drive spi_miso = TX shifter bit 7 while CS active, spi_miso_oe = cs_active; spi_miso = 1 when idle.
REQ-016 SHALL count bits 0..7; on 8th sampling edge push received byte to RX storage and wrap count to 0; on next SCK falling edge reload TX shifter per REQ-014.
REQ-017 SHALL, if RX storage is full when a byte completes, drop the new byte and set overrun.
REQ-018 SHALL, on CS rising mid-byte, discard partial byte and clear bit count; no push, no flags.
REQ-019 SHALL, when a byte completes in the same cycle as an RXDATA pop with storage full, perform the pop then the push, no overrun.
REQ-020 SHALL, when TXDATA write and LOAD/reload coincide, load the written byte into the shifter and leave tx_empty set.
REQ-021 SHALL read RXDATA as 0x00 when empty, without state change.
REQ-022 SHALL assert intr = (rx_irq_en & rx_avail) | (tx_irq_en & tx_empty) | overrun.

Reset
REQ-023 SHALL on rst low, asynchronously: wb_ack_o=0, wb_dat_o=0, state IDLE, bit count 0, shifters 0, RX storage empty, TX holding 0, tx_empty=1, overrun=0, underrun=0, CTRL=0, intr=0, spi_miso=1, spi_miso_oe=0, synchronisers to idle levels (SCK 0, CS 1).
REQ-024 SHALL, on reset mid-frame, abandon the frame and require a fresh CS falling edge after release.

Configuration
REQ-025 SHALL with SPI_SLAVE_RXFIFO_EN defined implement RX storage as a 4-entry FIFO (full = 4 bytes unread); without it a single-byte buffer (full = 1 byte unread); all other behaviour identical.

Verification
REQ-026 SHALL cover: write TXDATA 0xA5, master sends 0x3C -> master receives 0xA5, RXDATA reads 0x3C, tx_empty=1, rx_avail=0 after read.
REQ-027 SHALL cover: no TXDATA write, one frame -> MISO returns 0xFF, STATUS underrun=1; write STATUS 0x10 -> underrun=0.
REQ-028 SHALL cover: master sends 0x01..0x05 without reads -> with macro RX reads 0x01..0x04, overrun=1; without macro RX reads 0x01, overrun=1.
REQ-029 SHALL cover: CS raised after 5 bits, then full frame 0x81 -> exactly one byte 0x81 received.
REQ-030 SHALL cover: CTRL=0x1, frame 0x55 -> intr=1 until RXDATA read, then intr=0.
REQ-031 SHALL cover: rst low mid-frame after 3 bits -> all outputs at REQ-023 values in same cycle; next full frame 0xC3 received correctly.
